// File: rtl/adc_avg_decim.sv
// adc_avg_decim: per-channel boxcar average over 2^LOG2_DEC samples,
// decimating by the same factor, with a one-deep output register.
//
// Output handshake: a result is transferred on every rising edge where
// oVALID and iREADY are both 1. While oVALID=1 and iREADY=0, oDATA/oOTR hold.
// oVALID never drops without a transfer. A window that completes while the
// output is held is lost, and oOVF pulses for one cycle.
module adc_avg_decim #(
    parameter int CH_NUM   = 2,
    parameter int D_BIT    = 10,
    parameter int LOG2_DEC = 3
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic                    iEN,
    input  logic                    iDFS,
    input  logic [CH_NUM*D_BIT-1:0] iDATA,
    input  logic                    iVALID,
    input  logic [CH_NUM-1:0]       iOTR,
    input  logic                    iREADY,
    output logic [CH_NUM*D_BIT-1:0] oDATA,
    output logic                    oVALID,
    output logic [CH_NUM-1:0]       oOTR,
    output logic                    oOVF,
    output logic                    oSTATE   // 1 = ACC, 0 = IDLE
);

    // The accumulator has LOG2_DEC bits of headroom, so a full window of
    // extreme samples can never overflow it.
    localparam int AW = D_BIT + LOG2_DEC;

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [LOG2_DEC-1:0]   cnt_q;
    logic signed [AW-1:0]  acc_q  [CH_NUM];
    logic signed [AW-1:0]  sum    [CH_NUM];
    logic [D_BIT-1:0]      conv   [CH_NUM];
    logic [CH_NUM*D_BIT-1:0] result;
    logic [CH_NUM-1:0]     otr_q, otr_win;
    logic                  take, clr, complete, load, drop;

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and datapath controls. Dropping iEN discards the partial
    // window in either state; samples are taken whenever iEN is high.
    always_comb begin
        state_d  = state_q;
        clr      = !iEN;
        take     = iEN && iVALID;
        complete = take && (&cnt_q);
        load     = complete && (!oVALID || iREADY);
        drop     = complete && oVALID && !iREADY;
        case (state_q)
            IDLE:    if (iEN)  state_d = ACC;
            ACC:     if (!iEN) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Signed conversion, running sums and the averaged result. Straight
    // binary becomes two's complement by flipping the MSB; the average is
    // the top D_BIT bits of the sum, which floors toward minus infinity.
    always_comb begin
        result = '0;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            conv[ch]          = iDATA[ch*D_BIT +: D_BIT];
            conv[ch][D_BIT-1] = iDATA[ch*D_BIT + D_BIT - 1] ^ ~iDFS;
            sum[ch]           = acc_q[ch] + {{LOG2_DEC{conv[ch][D_BIT-1]}}, conv[ch]};
            result[ch*D_BIT +: D_BIT] = sum[ch][AW-1 -: D_BIT];
        end
        otr_win = otr_q | iOTR;
    end

    // Window accumulators, sample counter and windowed OTR flags.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q <= '0;
            otr_q <= '0;
            for (int ch = 0; ch < CH_NUM; ch++) acc_q[ch] <= '0;
        end else if (clr || complete) begin
            cnt_q <= '0;
            otr_q <= '0;
            for (int ch = 0; ch < CH_NUM; ch++) acc_q[ch] <= '0;
        end else if (take) begin
            cnt_q <= cnt_q + LOG2_DEC'(1);
            otr_q <= otr_win;
            for (int ch = 0; ch < CH_NUM; ch++) acc_q[ch] <= sum[ch];
        end
    end

    // Output register, valid flag and overflow pulse.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oDATA  <= '0;
            oOTR   <= '0;
            oVALID <= 1'b0;
            oOVF   <= 1'b0;
        end else begin
            oOVF <= drop;
            if (load) begin
                oDATA  <= result;
                oOTR   <= otr_win;
                oVALID <= 1'b1;
            end else if (oVALID && iREADY) begin
                oVALID <= 1'b0;
            end
        end
    end

    assign oSTATE = (state_q == ACC);

endmodule

// File: tb/tb_adc_avg_decim.sv
// tb_adc_avg_decim: directed and randomized checks of adc_avg_decim
// (CH_NUM=2, D_BIT=10, LOG2_DEC=3) against a window-level reference model.
module tb_adc_avg_decim;

    localparam int N = 8;
    localparam int W = 22;   // {otr[1:0], ch1[9:0], ch0[9:0]}

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iEN, iDFS, iVALID, iREADY;
    logic [19:0] iDATA;
    logic [1:0]  iOTR;
    logic [19:0] oDATA;
    logic        oVALID, oOVF, oSTATE;
    logic [1:0]  oOTR;

    int checks = 0;
    int errors = 0;

    // Reference model: the samples of the open window as plain integers.
    int         win0[$];
    int         win1[$];
    logic [1:0] win_otr;
    logic [W-1:0] exp_q[$];

    adc_avg_decim #(.CH_NUM(2), .D_BIT(10), .LOG2_DEC(3)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iDFS(iDFS),
        .iDATA(iDATA), .iVALID(iVALID), .iOTR(iOTR), .iREADY(iREADY),
        .oDATA(oDATA), .oVALID(oVALID), .oOTR(oOTR), .oOVF(oOVF),
        .oSTATE(oSTATE)
    );

    // Clock.
    always #5 iCLK = ~iCLK;

    function automatic int to_signed(input logic [9:0] raw, input logic dfs);
        if (dfs) return int'($signed(raw));
        return int'(raw) - 512;
    endfunction

    function automatic int floor_avg(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    task automatic model_clear();
        win0.delete();
        win1.delete();
        win_otr = 2'b00;
    endtask

    task automatic model_accept(input logic [9:0] d0, input logic [9:0] d1,
                                input logic [1:0] otr, input logic dfs);
        int s0, s1;
        win0.push_back(to_signed(d0, dfs));
        win1.push_back(to_signed(d1, dfs));
        win_otr = win_otr | otr;
        if (win0.size() == N) begin
            s0 = 0;
            s1 = 0;
            foreach (win0[i]) s0 += win0[i];
            foreach (win1[i]) s1 += win1[i];
            exp_q.push_back({win_otr, 10'(floor_avg(s1)), 10'(floor_avg(s0))});
            model_clear();
        end
    endtask

    // Driver: presents one sample for one clock, then returns #1 after the edge.
    task automatic send(input logic [9:0] d0, input logic [9:0] d1,
                        input logic [1:0] otr, input logic dfs);
        iDATA  = {d1, d0};
        iOTR   = otr;
        iDFS   = dfs;
        iVALID = 1'b1;
        if (iEN) model_accept(d0, d1, otr, dfs);
        else     model_clear();
        @(posedge iCLK); #1;
        iVALID = 1'b0;
        iOTR   = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (!iEN) model_clear();
            @(posedge iCLK); #1;
        end
    endtask

    task automatic test_reset();
        iRST_N = 1'b0; iEN = 1'b0; iDFS = 1'b1; iVALID = 1'b0;
        iREADY = 1'b1; iDATA = '0; iOTR = '0;
        model_clear();
        repeat (3) @(posedge iCLK);
        #1;
        checks++;
        if ({oVALID, oOVF, oOTR, oDATA, oSTATE} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b ovf=%b otr=%b data=%h st=%b required all 0",
                     oVALID, oOVF, oOTR, oDATA, oSTATE);
        end
        iRST_N = 1'b1;
        idle(1);
        checks++;
        if (oSTATE !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_state: got %b required 0", oSTATE);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] e;
        iEN = 1'b1; iREADY = 1'b1;
        for (int i = 0; i < N; i++) begin
            send(10'd100, 10'(-4), 2'b00, 1'b1);
            if (i == 0) begin
                checks++;
                if (oSTATE !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_state_acc: got %b required 1", oSTATE);
                end
            end
            if (i == N - 2) begin
                checks++;
                if (oVALID !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_valid: got %b required 0 after 7 samples", oVALID);
                end
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (oVALID !== 1'b1 || {oOTR, oDATA} !== e) begin
            errors++;
            $display("FAIL basic_result: got v=%b %h required v=1 %h", oVALID, {oOTR, oDATA}, e);
        end
        idle(1);
        checks++;
        if (oVALID !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_clear: got %b required 0", oVALID);
        end
    endtask

    task automatic test_offset_binary();
        logic [W-1:0] e;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < N; i++) send((w == 0) ? 10'd1023 : 10'd512, 10'd0, 2'b00, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (oVALID !== 1'b1 || {oOTR, oDATA} !== e) begin
                errors++;
                $display("FAIL offset_binary_w%0d: got v=%b %h required v=1 %h",
                         w, oVALID, {oOTR, oDATA}, e);
            end
            idle(1);
        end
    endtask

    task automatic test_ramp_floor();
        logic [W-1:0] e;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < N; i++)
                send(10'(((w == 0) ? -8 : -3) + i), 10'(i * 37 - 100), 2'b00, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (oVALID !== 1'b1 || {oOTR, oDATA} !== e) begin
                errors++;
                $display("FAIL ramp_floor_w%0d: got v=%b %h required v=1 %h",
                         w, oVALID, {oOTR, oDATA}, e);
            end
            idle(1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < N; i++) begin
                send(10'($urandom), 10'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00,
                     1'($urandom));
                if (i != N - 1) idle($urandom_range(0, 2));
            end
            e = exp_q.pop_front();
            checks++;
            if (oVALID !== 1'b1 || {oOTR, oDATA} !== e) begin
                errors++;
                $display("FAIL random_w%0d: got v=%b %h required v=1 %h",
                         w, oVALID, {oOTR, oDATA}, e);
            end
        end
        idle(1);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a;
        iREADY = 1'b0;
        for (int i = 0; i < N; i++) send(10'($urandom), 10'($urandom), 2'b00, 1'b1);
        a = exp_q.pop_front();
        for (int i = 0; i < N; i++) send(10'($urandom), 10'($urandom), 2'b01, 1'b1);
        void'(exp_q.pop_front());   // lost: output register was still full
        checks++;
        if (oVALID !== 1'b1 || {oOTR, oDATA} !== a || oOVF !== 1'b1) begin
            errors++;
            $display("FAIL bp_drop: got v=%b %h ovf=%b required v=1 %h ovf=1",
                     oVALID, {oOTR, oDATA}, oOVF, a);
        end
        idle(1);
        checks++;
        if (oOVF !== 1'b0 || {oOTR, oDATA} !== a) begin
            errors++;
            $display("FAIL bp_ovf_pulse: got ovf=%b %h required ovf=0 %h", oOVF, {oOTR, oDATA}, a);
        end
        iREADY = 1'b1;
        idle(1);
        checks++;
        if (oVALID !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got v=%b required 0", oVALID);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        iREADY = 1'b0;
        for (int i = 0; i < N; i++) send(10'($urandom), 10'($urandom), 2'b00, 1'b1);
        a = exp_q.pop_front();
        checks++;
        if (oVALID !== 1'b1 || {oOTR, oDATA} !== a) begin
            errors++;
            $display("FAIL b2b_first: got v=%b %h required v=1 %h", oVALID, {oOTR, oDATA}, a);
        end
        for (int i = 0; i < N - 1; i++) send(10'($urandom), 10'($urandom), 2'b00, 1'b1);
        iREADY = 1'b1;
        send(10'($urandom), 10'($urandom), 2'b00, 1'b1);
        b = exp_q.pop_front();
        checks++;
        if (oVALID !== 1'b1 || {oOTR, oDATA} !== b || oOVF !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reload: got v=%b %h ovf=%b required v=1 %h ovf=0",
                     oVALID, {oOTR, oDATA}, oOVF, b);
        end
        idle(1);
        checks++;
        if (oVALID !== 1'b0) begin
            errors++;
            $display("FAIL b2b_clear: got v=%b required 0", oVALID);
        end
    endtask

    task automatic test_otr();
        logic [W-1:0] e;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < N; i++)
                send(10'($urandom), 10'($urandom), (w == 0 && i == 2) ? 2'b10 : 2'b00, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (oVALID !== 1'b1 || {oOTR, oDATA} !== e || oOTR !== ((w == 0) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL otr_w%0d: got v=%b %h required v=1 %h", w, oVALID, {oOTR, oDATA}, e);
            end
            idle(1);
        end
    endtask

    task automatic test_enable_drop();
        logic [W-1:0] e;
        for (int i = 0; i < 5; i++) send(10'd300, 10'd200, 2'b01, 1'b1);
        iEN = 1'b0;
        idle(1);
        checks++;
        if (oSTATE !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_state: got %b required 0", oSTATE);
        end
        send(10'd500, 10'd500, 2'b11, 1'b1);   // ignored while disabled
        idle(1);
        iEN = 1'b1;
        for (int i = 0; i < N; i++) begin
            send(10'd7, 10'd7, 2'b00, 1'b1);
            if (i == N - 2) begin
                checks++;
                if (oVALID !== 1'b0) begin
                    errors++;
                    $display("FAIL en_drop_partial: got v=%b required 0 after 7 new samples", oVALID);
                end
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (oVALID !== 1'b1 || {oOTR, oDATA} !== e) begin
            errors++;
            $display("FAIL en_drop_result: got v=%b %h required v=1 %h", oVALID, {oOTR, oDATA}, e);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_window();
        logic [W-1:0] e;
        iREADY = 1'b0;
        for (int i = 0; i < N; i++) send(10'($urandom), 10'($urandom), 2'b10, 1'b1);
        for (int i = 0; i < 5; i++) send(10'($urandom), 10'($urandom), 2'b01, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (oVALID !== 1'b1 || {oOTR, oDATA} !== e) begin
            errors++;
            $display("FAIL rst_mid_held: got v=%b %h required v=1 %h", oVALID, {oOTR, oDATA}, e);
        end
        #2;
        iRST_N = 1'b0;
        #1;
        checks++;
        if ({oVALID, oOVF, oOTR, oDATA, oSTATE} !== 25'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got v=%b ovf=%b otr=%b data=%h st=%b required all 0",
                     oVALID, oOVF, oOTR, oDATA, oSTATE);
        end
        model_clear();
        @(posedge iCLK); #1;
        iRST_N = 1'b1;
        iREADY = 1'b1;
        for (int i = 0; i < N; i++) begin
            send(10'($urandom), 10'($urandom), 2'b00, 1'b1);
            if (i == N - 2) begin
                checks++;
                if (oVALID !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_mid_partial: got v=%b required 0 after 7 samples", oVALID);
                end
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (oVALID !== 1'b1 || {oOTR, oDATA} !== e) begin
            errors++;
            $display("FAIL rst_mid_result: got v=%b %h required v=1 %h", oVALID, {oOTR, oDATA}, e);
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset_binary();
        test_ramp_floor();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_otr();
        test_enable_drop();
        test_reset_mid_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_avg_decim.md
ADC_AVG_DECIM -- requirements
Module: adc_avg_decim

Interface
- REQ-001: Parameter CH_NUM, default 2: number of ADC channels packed side by side.
- REQ-002: Parameter D_BIT, default 10: sample width per channel.
- REQ-003: Parameter LOG2_DEC, default 3: decimation factor N = 2^LOG2_DEC, legal range 1..8.
- REQ-004: iCLK  in  1: single clock, rising edge, same domain as the upstream ADC capture stage.
- REQ-005: iRST_N  in  1: asynchronous active-low reset.
- REQ-006: iEN  in  1: 1 = accumulate; 0 = hold idle, partial window discarded.
- REQ-007: iDFS  in  1: input data format; 1 = two's complement, 0 = straight binary.
- REQ-008: iDATA  in  CH_NUM*D_BIT: channel k occupies bits [k*D_BIT +: D_BIT].
- REQ-009: iVALID  in  1: one-cycle strobe; the sample on iDATA/iOTR is valid.
- REQ-010: iOTR  in  CH_NUM: per-channel out-of-range flag, qualified by iVALID.
- REQ-011: iREADY  in  1: downstream accepts oDATA when iREADY and oVALID are both 1.
- REQ-012: oDATA  out  CH_NUM*D_BIT: per-channel signed two's-complement average, same packing as iDATA.
- REQ-013: oVALID  out  1: oDATA/oOTR hold a result not yet accepted.
- REQ-014: oOTR  out  CH_NUM: per-channel OR of iOTR over the window that produced oDATA.
- REQ-015: oOVF  out  1: one-cycle pulse; a completed result was dropped.

Function
- REQ-016: Each sample shall be converted to signed form: iDFS=1 passes unchanged; iDFS=0 inverts the MSB. iDFS is sampled per sample.
- REQ-017: Per channel, a signed accumulator of D_BIT+LOG2_DEC bits shall add each converted sample on iVALID=1 while iEN=1. Overflow is impossible by construction.
- REQ-018: A window counter of LOG2_DEC bits shall count accepted samples. On the Nth sample the window completes: the accumulator value including that sample is used, and the accumulator and counter restart at 0 in the same cycle.
- REQ-019: Result = accumulator arithmetically shifted right by LOG2_DEC, truncated toward minus infinity, with the low D_BIT bits kept.
- REQ-020: On completion, the result and the windowed OTR OR shall be loaded into the output register, and oVALID shall rise on the clock edge after the Nth iVALID (latency 1 cycle).
- REQ-021: The output register shall hold while oVALID=1 and iREADY=0. oVALID shall clear on the edge after the handshake unless a new result loads on that same edge.
- REQ-022: Completion in the same cycle as a handshake shall load the new result; oVALID stays 1 and oOVF stays 0.
- REQ-023: Completion while oVALID=1 and iREADY=0 shall drop the new result, leave the output register unchanged, and pulse oOVF for 1 cycle.
- REQ-024: State machine IDLE/ACC. IDLE->ACC when iEN=1. ACC->IDLE when iEN=0: accumulators, counter and OTR OR are cleared; the output register and handshake are unaffected.
- REQ-025: iVALID while iEN=0 shall be ignored.
- REQ-026: The windowed OTR OR shall clear at each window completion, so OTR never carries into the next window.

Reset
- REQ-027: While iRST_N=0, all of the following shall be 0: state (IDLE), accumulators, counter, oDATA, oVALID, oOTR, oOVF. Assertion takes effect immediately, independent of iCLK.
- REQ-028: Reset asserted mid-window shall discard the partial window. After release, the first result shall need a full N samples.

Verification (CH_NUM=2, D_BIT=10, LOG2_DEC=3, N=8)
- REQ-029: iDFS=1, 8 samples ch0=100, ch1=-4, iREADY=1 -> one cycle after the 8th iVALID, oVALID=1 with ch0=100, ch1=-4, oOTR=00.
- REQ-030: iDFS=0, ch0=1023, ch1=0 for 8 samples -> ch0=511, ch1=-512. Then ch0=512 for 8 samples -> ch0=0.
- REQ-031: iDFS=1, ch0 ramp -8..-1 -> ch0=-5 (sum -36, floor). Ramp -3..4 -> 0.
- REQ-032: iREADY=0 for two full windows -> first result held and oDATA unchanged; oOVF pulses 1 cycle at the second completion. Then iREADY=1 -> handshake, oVALID=0 on the next edge.
- REQ-033: iOTR=10 on the 3rd sample only -> that result carries oOTR=10; the next window gives oOTR=00.
- REQ-034: iEN dropped after 5 samples, then restored with 8 new samples of 7 -> result 7. In a separate run, iRST_N pulsed after 5 samples -> all outputs 0 at once, and the next result needs 8 samples.
